// File: rtl/popcount_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_pkg
//  Description : Shared constants and types for the unary (count-to-vector)
//                generator family.
//                  N  - frame length in bits
//                  CW - count width, $clog2(N+1)
//                  cnt_t / vec_t - count and frame vector types
//                  gen_state_e   - generator FSM states
//                  gen_mode_e    - thermometer / spread pattern select
//  Revision    : 1.0 - initial release
// ============================================================================
package popcount_pkg;

    localparam int N  = 20;
    localparam int CW = 5;

    typedef logic [CW-1:0] cnt_t;
    typedef logic [N-1:0]  vec_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } gen_state_e;

    typedef enum logic [0:0] {
        MODE_THERM  = 1'b0,
        MODE_SPREAD = 1'b1
    } gen_mode_e;

endpackage
`default_nettype wire

// File: rtl/popcount_unary_step.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_unary_step
//  Description : Combinational single-bit step of the unary generator.
//                Given the pattern mode, bit index, Bresenham accumulator and
//                target weight K it produces the frame bit and the next
//                accumulator value.
//  Ports       : i_mode     - MODE_THERM or MODE_SPREAD
//                i_idx      - bit index within the frame (0..N-1)
//                i_acc      - spread accumulator (0..N-1)
//                i_k        - target weight (0..N)
//                o_bit      - frame bit at i_idx
//                o_acc_next - accumulator after this bit
//  Revision    : 1.0 - initial release
// ============================================================================
module popcount_unary_step
    import popcount_pkg::*;
#(
    parameter int N  = popcount_pkg::N,
    parameter int CW = popcount_pkg::CW
) (
    input  gen_mode_e     i_mode,
    input  logic [CW-1:0] i_idx,
    input  logic [CW:0]   i_acc,
    input  logic [CW-1:0] i_k,
    output logic          o_bit,
    output logic [CW:0]   o_acc_next
);

    localparam logic [CW:0] C_N_ACC = (CW+1)'(N);

    logic [CW:0] w_sum;
    logic        w_spread_bit;

    // acc <= N-1 and K <= N, so acc+K <= 2N-1 which fits in CW+1 bits.
    always_comb begin
        w_sum        = i_acc + {1'b0, i_k};
        w_spread_bit = (w_sum >= C_N_ACC);
        o_bit        = 1'b0;
        o_acc_next   = i_acc;
        if (i_mode == MODE_SPREAD) begin
            o_bit      = w_spread_bit;
            o_acc_next = w_spread_bit ? (w_sum - C_N_ACC) : w_sum;
        end else begin
            o_bit      = (i_idx < i_k);
        end
    end

endmodule
`default_nettype wire

// File: rtl/popcount_unary_gen.sv
`default_nettype none
// ============================================================================
//  Module      : popcount_unary_gen
//  Description : Bit-serial weight-to-vector generator. Accepts a target
//                popcount K over a valid/ready handshake and emits an N-bit
//                frame containing exactly min(K,N) ones, one bit per beat,
//                then presents the assembled frame in parallel.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_cnt_valid/o_cnt_ready/i_cnt_data/i_cnt_mode - request
//                o_out_valid/i_out_ready/o_out_bit/o_out_last  - serial out
//                o_vec_valid/o_vec_data - completed frame (1-cycle pulse)
//                o_sat_err       - pulse when the request exceeded N
//  Revision    : 1.0 - initial release
// ============================================================================
module popcount_unary_gen
    import popcount_pkg::*;
#(
    parameter int N  = popcount_pkg::N,
    parameter int CW = popcount_pkg::CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_cnt_valid,
    output logic          o_cnt_ready,
    input  logic [CW-1:0] i_cnt_data,
    input  logic          i_cnt_mode,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic          o_out_bit,
    output logic          o_out_last,
    output logic          o_vec_valid,
    output logic [N-1:0]  o_vec_data,
    output logic          o_sat_err
);

    localparam logic [CW-1:0] C_N        = CW'(N);
    localparam logic [CW-1:0] C_LAST_IDX = CW'(N-1);

    gen_state_e    r_state;
    gen_state_e    w_state_next;
    gen_mode_e     r_mode;
    logic [CW-1:0] r_k;
    logic [CW-1:0] r_idx;
    logic [CW:0]   r_acc;
    logic [N-1:0]  r_vec;
    logic          r_vec_valid;
    logic          r_sat_err;

    logic          w_accept;
    logic          w_beat;
    logic          w_last;
    logic          w_sat;
    logic [CW-1:0] w_k_clamped;
    logic          w_bit;
    logic [CW:0]   w_acc_next;
    logic [N-1:0]  w_vec_next;

    assign w_accept    = (r_state == IDLE) && i_cnt_valid;
    assign w_beat      = (r_state == RUN) && i_out_ready;
    assign w_last      = (r_state == RUN) && (r_idx == C_LAST_IDX);
    assign w_sat       = (i_cnt_data > C_N);
    assign w_k_clamped = w_sat ? C_N : i_cnt_data;

    popcount_unary_step #(
        .N  (N),
        .CW (CW)
    ) u_step (
        .i_mode     (r_mode),
        .i_idx      (r_idx),
        .i_acc      (r_acc),
        .i_k        (r_k),
        .o_bit      (w_bit),
        .o_acc_next (w_acc_next)
    );

    // The previous frame stays visible until the first beat of the next
    // one; that beat clears the vector so unwritten bits read as 0.
    always_comb begin
        w_vec_next = r_vec;
        for (int i = 0; i < N; i++) begin
            if (r_idx == CW'(i)) begin
                w_vec_next[i] = w_bit;
            end else if (r_idx == '0) begin
                w_vec_next[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_cnt_valid)      w_state_next = RUN;
            RUN:     if (w_beat && w_last) w_state_next = IDLE;
            default:                       w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode      <= MODE_THERM;
            r_k         <= '0;
            r_idx       <= '0;
            r_acc       <= '0;
            r_vec       <= '0;
            r_vec_valid <= 1'b0;
            r_sat_err   <= 1'b0;
        end else begin
            r_vec_valid <= w_beat && w_last;
            r_sat_err   <= w_accept && w_sat;
            if (w_accept) begin
                r_k    <= w_k_clamped;
                r_mode <= gen_mode_e'(i_cnt_mode);
                r_idx  <= '0;
                r_acc  <= '0;
            end else if (w_beat) begin
                r_idx  <= r_idx + 1'b1;
                r_acc  <= w_acc_next;
                r_vec  <= w_vec_next;
            end
        end
    end

    // Ready is masked during reset so no request is seen as accepted then.
    assign o_cnt_ready = (r_state == IDLE) && !rst;
    assign o_out_valid = (r_state == RUN);
    assign o_out_bit   = (r_state == RUN) && w_bit;
    assign o_out_last  = w_last;
    assign o_vec_valid = r_vec_valid;
    assign o_vec_data  = r_vec;
    assign o_sat_err   = r_sat_err;

endmodule
`default_nettype wire

// File: tb/tb_popcount_unary_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_popcount_unary_gen
//  Description : Self-checking bench for popcount_unary_gen. Expected frames
//                come from a constant table and from an arithmetic model:
//                thermometer bit i = (i < K); spread bit i = 1 when
//                floor((i+1)K/N) > floor(iK/N).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_popcount_unary_gen;
    import popcount_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_cnt_valid;
    logic          o_cnt_ready;
    logic [CW-1:0] i_cnt_data;
    logic          i_cnt_mode;
    logic          o_out_valid;
    logic          i_out_ready;
    logic          o_out_bit;
    logic          o_out_last;
    logic          o_vec_valid;
    logic [N-1:0]  o_vec_data;
    logic          o_sat_err;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [N-1:0]  last_vec;

    always #5 clk = ~clk;

    popcount_unary_gen #(
        .N  (N),
        .CW (CW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_cnt_valid (i_cnt_valid),
        .o_cnt_ready (o_cnt_ready),
        .i_cnt_data  (i_cnt_data),
        .i_cnt_mode  (i_cnt_mode),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_bit   (o_out_bit),
        .o_out_last  (o_out_last),
        .o_vec_valid (o_vec_valid),
        .o_vec_data  (o_vec_data),
        .o_sat_err   (o_sat_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] model_vec(input logic mode, input int kin);
        int k;
        logic [N-1:0] v;
        k = (kin > N) ? N : kin;
        v = '0;
        for (int i = 0; i < N; i++) begin
            if (mode) v[i] = (((i + 1) * k) / N) > ((i * k) / N);
            else      v[i] = (i < k);
        end
        return v;
    endfunction

    function automatic int popcount20(input logic [N-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < N; i++) c += int'(v[i]);
        return c;
    endfunction

    // One complete request/frame with optional random back-pressure.
    task automatic run_frame(input logic mode, input int kin, input int stall_pct,
                             input logic check_time, input string tag);
        logic [N-1:0] exp_v;
        logic [N-1:0] ser;
        int   beats;
        int   cyc;
        logic rdy;
        logic prev_stall, prev_bit, prev_last;
        logic stable_ok, valid_ok, quiet_ok;
        exp_v = model_vec(mode, kin);
        ser   = '0;
        @(negedge clk);
        check({tag, " cnt_ready before request"}, o_cnt_ready, 1);
        i_cnt_valid = 1'b1;
        i_cnt_data  = CW'(kin);
        i_cnt_mode  = mode;
        @(negedge clk);
        i_cnt_valid = 1'b0;
        cyc = 1;
        check({tag, " out_valid at T+1"}, o_out_valid, 1);
        check({tag, " sat_err at T+1"}, o_sat_err, (kin > N));
        beats = 0;
        prev_stall = 1'b0; prev_bit = 1'b0; prev_last = 1'b0;
        stable_ok = 1'b1; valid_ok = 1'b1; quiet_ok = 1'b1;
        while (beats < N && cyc < 400) begin
            if (o_out_valid !== 1'b1) valid_ok = 1'b0;
            if (prev_stall && (o_out_bit !== prev_bit || o_out_last !== prev_last)) stable_ok = 1'b0;
            if (cyc > 1 && o_sat_err !== 1'b0) quiet_ok = 1'b0;
            if (o_vec_valid !== 1'b0) quiet_ok = 1'b0;
            rdy = ($urandom_range(99) >= stall_pct);
            i_out_ready = rdy;
            if (rdy) begin
                ser[beats] = o_out_bit;
                check({tag, " out_last"}, o_out_last, (beats == N - 1));
                beats++;
            end
            prev_stall = !rdy;
            prev_bit   = o_out_bit;
            prev_last  = o_out_last;
            @(negedge clk);
            cyc++;
        end
        i_out_ready = 1'b1;
        check({tag, " frame completed in bound"}, beats, N);
        check({tag, " stall stability"}, stable_ok, 1);
        check({tag, " out_valid held in frame"}, valid_ok, 1);
        check({tag, " no stray pulses in frame"}, quiet_ok, 1);
        check({tag, " vec_valid at L+1"}, o_vec_valid, 1);
        check({tag, " cnt_ready at L+1"}, o_cnt_ready, 1);
        check({tag, " out_valid low at L+1"}, o_out_valid, 0);
        check({tag, " vec_data"}, o_vec_data, exp_v);
        check({tag, " serial stream"}, ser, exp_v);
        check({tag, " popcount"}, popcount20(o_vec_data), (kin > N) ? N : kin);
        if (check_time) check({tag, " acceptance to vec_valid cycles"}, cyc, N + 1);
        last_vec = o_vec_data;
        @(negedge clk);
        check({tag, " vec_valid one cycle"}, o_vec_valid, 0);
        check({tag, " vec_data held"}, o_vec_data, exp_v);
    endtask

    task automatic run_b2b();
        int   kl[3];
        int   acc_cyc[3];
        int   nacc, nvec, cyc;
        logic change;
        kl = '{1, 2, 3};
        acc_cyc = '{0, 0, 0};
        nacc = 0; nvec = 0; cyc = 0; change = 1'b0;
        @(negedge clk);
        i_out_ready = 1'b1;
        i_cnt_mode  = 1'b1;
        i_cnt_valid = 1'b1;
        i_cnt_data  = CW'(kl[0]);
        while (nvec < 3 && cyc < 200) begin
            if (change) begin
                change = 1'b0;
                if (nacc < 3) i_cnt_data = CW'(kl[nacc]);
                else          i_cnt_valid = 1'b0;
            end
            if (o_vec_valid) begin
                check("b2b popcount", popcount20(o_vec_data), kl[nvec]);
                check("b2b vec_data", o_vec_data, model_vec(1'b1, kl[nvec]));
                nvec++;
            end
            if (o_cnt_ready && i_cnt_valid && nacc < 3) begin
                acc_cyc[nacc] = cyc;
                nacc++;
                change = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        i_cnt_valid = 1'b0;
        check("b2b frames seen", nvec, 3);
        check("b2b spacing 0-1", acc_cyc[1] - acc_cyc[0], N + 1);
        check("b2b spacing 1-2", acc_cyc[2] - acc_cyc[1], N + 1);
    endtask

    task automatic run_reset_mid_frame();
        logic quiet;
        @(negedge clk);
        i_out_ready = 1'b1;
        i_cnt_valid = 1'b1;
        i_cnt_data  = CW'(20);
        i_cnt_mode  = 1'b0;
        @(negedge clk);
        i_cnt_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("rst mid out_valid before", o_out_valid, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst mid cnt_ready", o_cnt_ready, 0);
        check("rst mid out_valid", o_out_valid, 0);
        check("rst mid out_bit", o_out_bit, 0);
        check("rst mid out_last", o_out_last, 0);
        check("rst mid vec_valid", o_vec_valid, 0);
        check("rst mid vec_data", o_vec_data, 0);
        check("rst mid sat_err", o_sat_err, 0);
        rst = 1'b0;
        @(negedge clk);
        check("rst mid cnt_ready after", o_cnt_ready, 1);
        quiet = 1'b1;
        repeat (25) begin
            if (o_vec_valid !== 1'b0 || o_sat_err !== 1'b0 || o_out_valid !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        check("rst mid no vec_valid/sat_err", quiet, 1);
        run_frame(1'b0, 4, 0, 1'b1, "post-rst");
        check("post-rst vec_data", last_vec, 20'h0000F);
    endtask

    typedef struct {
        logic         mode;
        int           kin;
        logic [N-1:0] exp_vec;
    } vec_rec_t;

    vec_rec_t tbl[9];
    logic [N-1:0] bp_ref;

    initial begin
        tbl[0] = '{1'b0,  7, 20'h0007F};
        tbl[1] = '{1'b1,  5, 20'h88888};
        tbl[2] = '{1'b1, 10, 20'hAAAAA};
        tbl[3] = '{1'b0, 25, 20'hFFFFF};
        tbl[4] = '{1'b1, 25, 20'hFFFFF};
        tbl[5] = '{1'b0,  0, 20'h00000};
        tbl[6] = '{1'b1,  0, 20'h00000};
        tbl[7] = '{1'b1, 20, 20'hFFFFF};
        tbl[8] = '{1'b0, 20, 20'hFFFFF};

        rst = 1'b1;
        i_cnt_valid = 1'b0;
        i_cnt_data  = '0;
        i_cnt_mode  = 1'b0;
        i_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("reset cnt_ready", o_cnt_ready, 0);
        check("reset out_valid", o_out_valid, 0);
        check("reset out_bit", o_out_bit, 0);
        check("reset out_last", o_out_last, 0);
        check("reset vec_valid", o_vec_valid, 0);
        check("reset vec_data", o_vec_data, 0);
        check("reset sat_err", o_sat_err, 0);
        rst = 1'b0;
        @(negedge clk);
        check("cnt_ready after reset", o_cnt_ready, 1);

        for (int i = 0; i < 9; i++) begin
            run_frame(tbl[i].mode, tbl[i].kin, 0, 1'b1, "tbl");
            check("tbl expected vector", last_vec, tbl[i].exp_vec);
        end

        run_frame(1'b1, 13, 0, 1'b1, "bp unstalled");
        bp_ref = last_vec;
        run_frame(1'b1, 13, 50, 1'b0, "bp stalled");
        check("bp matches unstalled", last_vec, bp_ref);

        run_b2b();
        run_reset_mid_frame();

        for (int i = 0; i < 12; i++) begin
            int stall;
            stall = int'($urandom_range(0, 60));
            run_frame(1'($urandom_range(1)), int'($urandom_range(0, 31)), stall,
                      (stall == 0), "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/popcount_unary_gen.md
# popcount_unary_gen

Bit-serial weight-to-vector generator: accepts a target popcount K (0..N) over a valid/ready handshake and emits an N-bit frame containing exactly K ones, one bit per accepted beat. It also presents the assembled vector in parallel at frame end. It is the decoding counterpart of the popcount20 family: it drives stimulus vectors of known weight into popcount cores, and serves as the count-to-unary stage of ternary-neuron datapaths.

## Interface
- N, default 20: frame length in bits.
- CW, default 5: count width, equal to $clog2(N+1).
- clk  in  1  sole clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cnt_valid  in  1  request valid.
- cnt_ready  out  1  block can accept a request.
- cnt_data  in  CW  target weight K.
- cnt_mode  in  1  0 = thermometer, 1 = spread; sampled with cnt_data.
- out_valid  out  1  serial bit valid.
- out_ready  in  1  downstream accepts the bit.
- out_bit  out  1  current frame bit.
- out_last  out  1  high on the final bit (index N-1) of the frame.
- vec_valid  out  1  one-cycle pulse; vec_data holds the completed frame.
- vec_data  out  N  bit i = i-th emitted bit.
- sat_err  out  1  one-cycle pulse when an accepted cnt_data exceeds N.

## Operation
- FSM states: IDLE, RUN.
- IDLE:
  - cnt_ready=1, out_valid=0.
  - On cnt_valid: latch K=min(cnt_data,N) and the mode, set idx=0, acc=0, then go to RUN.
  - If cnt_data>N, pulse sat_err the next cycle.
- RUN:
  - cnt_ready=0, out_valid=1.
  - out_bit is a function of the registered state only; it is stable while out_valid && !out_ready.
- Thermometer mode: out_bit = (idx < K).
- Spread mode (Bresenham accumulator):
  - acc is CW+1 bits wide, range 0..N-1.
  - out_bit = (acc + K >= N).
  - On each beat: acc <= out_bit ? acc+K-N : acc+K.
  - Exactly K ones per frame; acc returns to 0 at frame end.
- Beat rule: out_valid && out_ready. On each beat, idx increments and out_bit shifts into vec_data at position idx.
- Frame end: the beat with idx==N-1 (out_last=1) returns the FSM to IDLE. vec_valid pulses for one cycle in the following cycle, with vec_data holding the frame.
- Boundaries:
  - K=0 gives all zeros in both modes.
  - K=N gives all ones in both modes.
  - Spread with K=N never leaves acc at nonzero.
- Reset mid-frame: the frame is aborted. The FSM goes to IDLE and all outputs go to their reset values; no vec_valid and no sat_err are produced.
- Reset values: cnt_ready=0 during rst and 1 from the first cycle after; out_valid=0, out_bit=0, out_last=0, vec_valid=0, vec_data=0, sat_err=0.

## Timing
- Acceptance cycle T (cnt_valid && cnt_ready): out_valid first rises at T+1.
- Frame time is N cycles with continuous out_ready. Back-pressure stretches it one cycle per stalled beat.
- Last beat at cycle L: vec_valid=1 and cnt_ready=1 at L+1.
- Next acceptance at L+1 at the earliest. Peak throughput is one frame per N+1 cycles.
- vec_data is held until the next frame's first beat. During RUN it shows the partial frame, with unwritten bits at 0.
- sat_err pulses at T+1, coincident with the first out_valid.
- Stall rules: while out_valid && !out_ready, out_bit, out_last, idx and acc do not change. out_valid never drops inside a frame.

## Structure
- Package popcount_pkg holds:
  - constants N=20 and CW=5;
  - typedef cnt_t (logic [CW-1:0]);
  - typedef vec_t (logic [N-1:0]);
  - enum gen_state_e {IDLE, RUN};
  - enum gen_mode_e {MODE_THERM, MODE_SPREAD}.
- One sub-module, popcount_unary_step. It is purely combinational: from (mode, idx, acc, K) it produces (bit, acc_next). Keeping it separate lets it be reused by a parallel (unrolled) generator and checked exhaustively on its own.
- Top level holds the FSM, the idx/acc/K registers, the vec_data shift/insert, and the handshakes.

## Test plan
- Thermometer: K=7, out_ready=1 -> serial stream of 7 ones then 13 zeros; vec_data=0x0007F; vec_valid 21 cycles after acceptance; out_last on beat 19.
- Spread: K=5 -> ones at indices 3, 7, 11, 15, 19; vec_data=0x88888. K=10 -> vec_data=0xAAAAA.
- Saturation: cnt_data=25 in either mode -> sat_err pulse at T+1; vec_data=0xFFFFF. K=0 -> vec_data=0x00000, no sat_err.
- Back-pressure: K=13 spread with out_ready randomly deasserted ~50% -> out_bit/out_last stable across stalls; exactly 13 ones; vec_data matches the unstalled run.
- Back-to-back: cnt_valid held high with K=1, 2, 3 -> acceptances spaced 21 cycles apart; each vec_data has popcount K. Feeding vec_data through popcount20 golden model returns K.
- Reset at beat 9 of a K=20 frame -> all outputs 0 the next cycle; no vec_valid; cnt_ready=1 after rst drops; the next K=4 thermometer frame gives 0x0000F.
